inst_ctrl: RTL and testbench

//  Multi-cycle instruction controller that drives the ALU interface: fetches from instruction memory,

---
 rtl/inst_ctrl_pkg.sv | 93 +++++++++
 rtl/inst_ctrl_regfile.sv | 28 ++
 rtl/inst_ctrl.sv | 169 ++++++++++++++++
 tb/tb_inst_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_ctrl_pkg.sv
// Shared encodings for the multi-cycle instruction controller: opcodes, functs,
// ALU op codes, status codes, FSM states and the instruction decoder.
package inst_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_EOI   = 6'h3F;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_MUL  = 6'h18;
    localparam logic [5:0] FN_FADD = 6'h30;
    localparam logic [5:0] FN_FSUB = 6'h31;
    localparam logic [5:0] FN_FMUL = 6'h32;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_MUL  = 4'd2;
    localparam logic [3:0] ALU_FADD = 4'd3;
    localparam logic [3:0] ALU_FSUB = 4'd4;
    localparam logic [3:0] ALU_FMUL = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_NOR  = 4'd9;
    localparam logic [3:0] ALU_SLT  = 4'd10;
    localparam logic [3:0] ALU_SLL  = 4'd11;
    localparam logic [3:0] ALU_SRL  = 4'd12;

    localparam logic [2:0] ST_R_OK  = 3'd0;
    localparam logic [2:0] ST_I_OK  = 3'd1;
    localparam logic [2:0] ST_ERROR = 3'd2;
    localparam logic [2:0] ST_END   = 3'd3;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        K_ILLEGAL, K_ALU, K_SHIFT, K_ADDI, K_LW, K_SW, K_BEQ, K_BNE, K_EOI
    } kind_t;

    typedef struct packed {
        kind_t      kind;
        logic [3:0] alu_op;
        logic       ovf_chk;    // overflow on this op is an architectural error
        logic [2:0] ok_status;  // status reported when nothing goes wrong
    } dec_t;

    function automatic dec_t decode(input logic [5:0] opcode, input logic [5:0] funct);
        dec_t d;
        d = '{kind: K_ILLEGAL, alu_op: ALU_ADD, ovf_chk: 1'b0, ok_status: ST_ERROR};
        case (opcode)
            OP_RTYPE: begin
                d.kind      = K_ALU;
                d.ok_status = ST_R_OK;
                case (funct)
                    FN_ADD:  begin d.alu_op = ALU_ADD; d.ovf_chk = 1'b1; end
                    FN_SUB:  begin d.alu_op = ALU_SUB; d.ovf_chk = 1'b1; end
                    FN_MUL:  begin d.alu_op = ALU_MUL; d.ovf_chk = 1'b1; end
                    FN_FADD: d.alu_op = ALU_FADD;
                    FN_FSUB: d.alu_op = ALU_FSUB;
                    FN_FMUL: d.alu_op = ALU_FMUL;
                    FN_AND:  d.alu_op = ALU_AND;
                    FN_OR:   d.alu_op = ALU_OR;
                    FN_NOR:  d.alu_op = ALU_NOR;
                    FN_SLT:  d.alu_op = ALU_SLT;
                    FN_SLL:  begin d.alu_op = ALU_SLL; d.kind = K_SHIFT; end
                    FN_SRL:  begin d.alu_op = ALU_SRL; d.kind = K_SHIFT; end
                    default: d.kind = K_ILLEGAL;
                endcase
            end
            OP_ADDI: begin d.kind = K_ADDI; d.ovf_chk = 1'b1; d.ok_status = ST_I_OK; end
            OP_LW:   begin d.kind = K_LW;  d.ok_status = ST_I_OK; end
            OP_SW:   begin d.kind = K_SW;  d.ok_status = ST_I_OK; end
            OP_BEQ:  begin d.kind = K_BEQ; d.alu_op = ALU_SUB; d.ok_status = ST_I_OK; end
            OP_BNE:  begin d.kind = K_BNE; d.alu_op = ALU_SUB; d.ok_status = ST_I_OK; end
            OP_EOI:  begin d.kind = K_EOI; d.ok_status = ST_END; end
            default: d.kind = K_ILLEGAL;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/inst_ctrl_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// r0 hard-wired to zero.
module inst_ctrl_regfile (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd
);

    logic [31:0] regs [32];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (i_we && (i_wa != 5'd0)) begin
            regs[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : regs[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : regs[i_ra2];

endmodule

// File: rtl/inst_ctrl.sv
// Five-state instruction controller: fetch, decode, drive the external ALU,
// access data memory and write back, with one status pulse per instruction.
module inst_ctrl
    import inst_ctrl_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = 4096,
    parameter int unsigned DMEM_BYTES = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_i_addr,
    input  logic [31:0] i_inst,
    output logic [3:0]  o_alu_op,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    input  logic [31:0] i_alu_result,
    input  logic        i_alu_overflow,
    input  logic        i_alu_equal,
    output logic        o_d_we,
    output logic [31:0] o_d_addr,
    output logic [31:0] o_d_wdata,
    input  logic [31:0] i_d_rdata,
    output logic [2:0]  o_status,
    output logic        o_status_valid
);

    state_t      state, state_nxt;
    logic [31:0] pc, rs_q, rt_q, res_q, npc_q;
    logic [20:0] fld_q;     // rt, rd, shamt and imm fields of the current instruction
    dec_t        dec_q;
    logic        err_q;
    logic [2:0]  status_q;

    logic [31:0] rd1, rd2, imm_sext, npc, wd;
    logic [4:0]  wa;
    logic        we, taken, is_mem, exec_err;

    inst_ctrl_regfile u_rf (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_ra1 (i_inst[25:21]),
        .i_ra2 (i_inst[20:16]),
        .o_rd1 (rd1),
        .o_rd2 (rd2),
        .i_we  (we),
        .i_wa  (wa),
        .i_wd  (wd)
    );

    assign imm_sext = {{16{fld_q[15]}}, fld_q[15:0]};
    assign is_mem   = (dec_q.kind == K_LW) || (dec_q.kind == K_SW);

    // Everything that can go wrong is known by the end of EXEC, so later states
    // only have to consult err_q.
    always_comb begin
        taken = ((dec_q.kind == K_BEQ) &&  i_alu_equal) ||
                ((dec_q.kind == K_BNE) && !i_alu_equal);
        npc   = pc + 32'd4 + (taken ? {imm_sext[29:0], 2'b00} : 32'd0);
        exec_err = (dec_q.kind == K_ILLEGAL) ||
                   (dec_q.ovf_chk && i_alu_overflow) ||
                   (is_mem && (i_alu_result >= 32'(DMEM_BYTES))) ||
                   (npc >= 32'(IMEM_BYTES));
        if (dec_q.kind == K_EOI) exec_err = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= S_FETCH;
            pc       <= '0;
            fld_q    <= '0;
            dec_q    <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            res_q    <= '0;
            npc_q    <= '0;
            err_q    <= 1'b0;
            status_q <= ST_R_OK;
        end else begin
            state <= state_nxt;
            case (state)
                S_DECODE: begin
                    fld_q <= i_inst[20:0];
                    dec_q <= decode(i_inst[31:26], i_inst[5:0]);
                    rs_q  <= rd1;
                    rt_q  <= rd2;
                end
                S_EXEC: begin
                    res_q    <= i_alu_result;
                    npc_q    <= npc;
                    err_q    <= exec_err;
                    status_q <= exec_err ? ST_ERROR : dec_q.ok_status;
                end
                S_WB: begin
                    if (!err_q && (dec_q.kind != K_EOI)) pc <= npc_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_MEM;
            S_MEM:    state_nxt = S_WB;
            S_WB:     state_nxt = (err_q || (dec_q.kind == K_EOI)) ? S_HALT : S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        o_alu_op = '0;
        o_alu_a  = '0;
        o_alu_b  = '0;
        if (state == S_EXEC) begin
            o_alu_op = dec_q.alu_op;
            case (dec_q.kind)
                K_SHIFT: begin
                    o_alu_a = rt_q;
                    o_alu_b = {27'd0, fld_q[10:6]};
                end
                K_ADDI, K_LW, K_SW: begin
                    o_alu_a = rs_q;
                    o_alu_b = imm_sext;
                end
                default: begin
                    o_alu_a = rs_q;
                    o_alu_b = rt_q;
                end
            endcase
        end
    end

    // Memory strobes are decoded from state, so an async reset kills them at once.
    always_comb begin
        o_d_we    = 1'b0;
        o_d_addr  = '0;
        o_d_wdata = '0;
        if ((state == S_MEM) && is_mem && !err_q) begin
            o_d_addr = res_q;
            if (dec_q.kind == K_SW) begin
                o_d_we    = 1'b1;
                o_d_wdata = rt_q;
            end
        end
    end

    always_comb begin
        we = 1'b0;
        wa = fld_q[20:16];
        wd = res_q;
        if ((state == S_WB) && !err_q) begin
            case (dec_q.kind)
                K_ALU, K_SHIFT: begin we = 1'b1; wa = fld_q[15:11]; end
                K_ADDI:         we = 1'b1;
                K_LW:           begin we = 1'b1; wd = i_d_rdata; end
                default:        ;
            endcase
        end
    end

    assign o_i_addr       = pc;
    assign o_status_valid = (state == S_WB);
    assign o_status       = (state == S_WB) ? status_q : ST_R_OK;

endmodule

// File: tb/tb_inst_ctrl.sv
// Bench for inst_ctrl: memory and ALU models around the DUT, and an ISA-level
// reference that predicts status, stores and next PC for each instruction.
module tb_inst_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] o_i_addr;
    logic [31:0] i_inst = '0;
    logic [3:0]  o_alu_op;
    logic [31:0] o_alu_a, o_alu_b;
    logic [31:0] i_alu_result;
    logic        i_alu_overflow, i_alu_equal;
    logic        o_d_we;
    logic [31:0] o_d_addr, o_d_wdata;
    logic [31:0] i_d_rdata = '0;
    logic [2:0]  o_status;
    logic        o_status_valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] imem  [1024];
    logic [31:0] dmem  [1024];
    logic [31:0] m_dm  [1024];
    logic [31:0] m_regs[32];
    logic [31:0] m_pc;
    logic [63:0] sq[$];

    localparam logic [31:0] EOI = 32'hFC00_0000;

    inst_ctrl dut (
        .i_clk(i_clk), .i_rst(i_rst), .o_i_addr(o_i_addr), .i_inst(i_inst),
        .o_alu_op(o_alu_op), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
        .i_alu_result(i_alu_result), .i_alu_overflow(i_alu_overflow),
        .i_alu_equal(i_alu_equal), .o_d_we(o_d_we), .o_d_addr(o_d_addr),
        .o_d_wdata(o_d_wdata), .i_d_rdata(i_d_rdata), .o_status(o_status),
        .o_status_valid(o_status_valid)
    );

    always #5 i_clk = ~i_clk;

    // ALU stand-in; the float ops are just distinct integer functions.
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a * b;
            4'd3:  return (a + b) ^ 32'h5A5A_5A5A;
            4'd4:  return (a - b) ^ 32'hA5A5_A5A5;
            4'd5:  return (a * b) ^ 32'h3C3C_3C3C;
            4'd7:  return a & b;
            4'd8:  return a | b;
            4'd9:  return ~(a | b);
            4'd10: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd11: return a << b[4:0];
            4'd12: return a >> b[4:0];
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic alu_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s, d;
        longint p;
        s = a + b;
        d = a - b;
        p = longint'($signed(a)) * longint'($signed(b));
        case (op)
            4'd0, 4'd3: return (a[31] == b[31]) && (s[31] != a[31]);
            4'd1:       return (a[31] != b[31]) && (d[31] != a[31]);
            4'd2:       return p != longint'($signed(p[31:0]));
            default:    return 1'b0;
        endcase
    endfunction

    assign i_alu_result   = alu_f(o_alu_op, o_alu_a, o_alu_b);
    assign i_alu_overflow = alu_ovf(o_alu_op, o_alu_a, o_alu_b);
    assign i_alu_equal    = (o_alu_a == o_alu_b);

    always @(posedge i_clk) begin
        i_inst    <= imem[o_i_addr[11:2]];
        i_d_rdata <= dmem[o_d_addr[11:2]];
        if (o_d_we) dmem[o_d_addr[11:2]] <= o_d_wdata;
    end

    always @(negedge i_clk) if (o_d_we) sq.push_back({o_d_addr, o_d_wdata});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 1024; i++) imem[i] = EOI;
    endtask

    task automatic init_dmem();
        for (int i = 0; i < 1024; i++) begin
            dmem[i] = $urandom;
            m_dm[i] = dmem[i];
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("rst_i_addr", o_i_addr, 32'd0);
        chk("rst_ctl", {23'd0, o_d_we, o_status_valid, o_status, o_alu_op}, 32'd0);
        chk("rst_data", o_d_addr | o_d_wdata | o_alu_a | o_alu_b, 32'd0);
        i_rst = 1'b0;
    endtask

    // Architectural reference: executes one instruction on m_regs/m_dm/m_pc.
    task automatic model_step(input logic [31:0] ins, output logic [2:0] st, output bit sv,
                              output logic [31:0] sa, output logic [31:0] sd, output bit halt);
        logic [31:0] rs, rt, imm, res, npc, a, b;
        logic [3:0]  aop;
        logic [4:0]  wreg;
        bit err, wr, ovc;
        rs = m_regs[ins[25:21]];
        rt = m_regs[ins[20:16]];
        imm = {{16{ins[15]}}, ins[15:0]};
        npc = m_pc + 32'd4;
        err = 0; wr = 0; ovc = 0; sv = 0; halt = 0;
        sa = '0; sd = '0; res = '0; aop = '0; wreg = '0; st = 3'd1;
        a = rs; b = rt;
        case (ins[31:26])
            6'h00: begin
                st = 3'd0; wreg = ins[15:11]; wr = 1;
                case (ins[5:0])
                    6'h20: begin aop = 0; ovc = 1; end
                    6'h22: begin aop = 1; ovc = 1; end
                    6'h18: begin aop = 2; ovc = 1; end
                    6'h30: aop = 3;
                    6'h31: aop = 4;
                    6'h32: aop = 5;
                    6'h24: aop = 7;
                    6'h25: aop = 8;
                    6'h27: aop = 9;
                    6'h2A: aop = 10;
                    6'h00: begin aop = 11; a = rt; b = {27'd0, ins[10:6]}; end
                    6'h02: begin aop = 12; a = rt; b = {27'd0, ins[10:6]}; end
                    default: err = 1;
                endcase
                res = alu_f(aop, a, b);
                if (ovc && alu_ovf(aop, a, b)) err = 1;
            end
            6'h08: begin
                res = rs + imm; wreg = ins[20:16]; wr = 1;
                if (alu_ovf(4'd0, rs, imm)) err = 1;
            end
            6'h23: begin
                sa = rs + imm;
                if (sa >= 32'd4096) err = 1;
                else begin res = m_dm[sa[11:2]]; wr = 1; wreg = ins[20:16]; end
            end
            6'h2B: begin
                sa = rs + imm;
                if (sa >= 32'd4096) err = 1;
                else begin sv = 1; sd = rt; end
            end
            6'h04, 6'h05: if ((rs == rt) == (ins[31:26] == 6'h04)) npc = npc + (imm << 2);
            6'h3F: begin st = 3'd3; halt = 1; end
            default: err = 1;
        endcase
        if (ins[31:26] != 6'h3F && npc >= 32'd4096) err = 1;
        if (err) begin
            st = 3'd2; halt = 1; sv = 0;
        end else if (!halt) begin
            if (wr && wreg != 5'd0) m_regs[wreg] = res;
            if (sv) m_dm[sa[11:2]] = sd;
            m_pc = npc;
        end
    endtask

    task automatic wait_pulse(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge i_clk);
            k++;
        end while (!o_status_valid && k < 12);
        chk({tag, "_latency"}, k, 32'd4);
    endtask

    // Runs the program in imem from reset and checks every instruction.
    task automatic run_prog(input string tag);
        logic [2:0]  est;
        logic [31:0] ins, sa, sd;
        bit sv, halt;
        int n, pulses, moves, stores;
        init_dmem();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc = '0;
        do_reset();
        sq.delete();
        halt = 0;
        n = 0;
        while (!halt && n < 64) begin
            ins = imem[m_pc[11:2]];
            model_step(ins, est, sv, sa, sd, halt);
            wait_pulse($sformatf("%s_%0d", tag, n));
            chk($sformatf("%s_%0d_status", tag, n), 32'(o_status), 32'(est));
            chk($sformatf("%s_%0d_nstore", tag, n), sq.size(), sv ? 32'd1 : 32'd0);
            if (sv && sq.size() == 1) begin
                chk($sformatf("%s_%0d_st_addr", tag, n), sq[0][63:32], sa);
                chk($sformatf("%s_%0d_st_data", tag, n), sq[0][31:0], sd);
            end
            sq.delete();
            if (!halt) begin
                @(negedge i_clk);
                chk($sformatf("%s_%0d_next_pc", tag, n), o_i_addr, m_pc);
            end
            n++;
        end
        pulses = 0; moves = 0;
        repeat (20) begin
            @(negedge i_clk);
            if (o_status_valid) pulses++;
            if (o_i_addr !== m_pc) moves++;
        end
        stores = sq.size();
        chk({tag, "_halt_pulses"}, pulses, 32'd0);
        chk({tag, "_halt_pc"}, moves, 32'd0);
        chk({tag, "_halt_stores"}, stores, 32'd0);
    endtask

    initial begin
        logic [31:0] saved;
        logic [5:0]  fl [13];
        int r;
        fl = '{6'h20, 6'h22, 6'h18, 6'h30, 6'h31, 6'h32, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h3E};

        // addi/sw/lw/beq/bne then a real signed overflow on add
        clear_imem();
        imem[0]  = 32'h2001_0005;                    // addi r1,r0,5
        imem[1]  = enc_i(6'h2B, 0, 1, 16'd8);         // sw r1,8(r0)
        imem[2]  = enc_i(6'h23, 0, 3, 16'd8);         // lw r3,8(r0)
        imem[3]  = enc_i(6'h2B, 0, 3, 16'd12);        // sw r3,12(r0)
        imem[4]  = enc_i(6'h04, 1, 3, 16'd2);         // beq at 0x10 -> 0x1C
        imem[7]  = enc_i(6'h05, 1, 3, 16'd1);         // bne not taken
        imem[8]  = enc_i(6'h08, 0, 4, 16'hFFFF);      // r4 = -1
        imem[9]  = enc_r(0, 4, 5, 1, 6'h02);          // r5 = 0x7FFFFFFF
        imem[10] = enc_i(6'h08, 0, 2, 16'd1);         // r2 = 1
        imem[11] = enc_r(5, 2, 6, 0, 6'h20);          // add overflows
        imem[12] = enc_i(6'h2B, 0, 6, 16'd16);        // never reached
        run_prog("basic");

        // store to the first out-of-range data address
        clear_imem();
        imem[0] = enc_i(6'h08, 0, 1, 16'h1000);
        imem[1] = enc_i(6'h2B, 1, 1, 16'd0);
        run_prog("sw_oor");

        // eoi halts cleanly
        clear_imem();
        imem[0] = enc_i(6'h08, 0, 1, 16'd3);
        run_prog("eoi");

        // bne with equal operands at 0x10 falls through to 0x14
        clear_imem();
        for (int i = 0; i < 4; i++) imem[i] = enc_i(6'h08, 0, 0, 16'd9);
        imem[4] = enc_i(6'h05, 0, 0, 16'd5);
        imem[5] = enc_i(6'h2B, 0, 0, 16'd4);
        run_prog("bne_eq");

        // branch to last word, then PC steps to IMEM_BYTES; lw at 4092 is legal
        clear_imem();
        imem[0]    = enc_i(6'h04, 0, 0, 16'd1022);
        imem[1023] = enc_i(6'h23, 0, 2, 16'd4092);
        run_prog("pc_oor");

        // reset asserted during the MEM cycle of a store
        clear_imem();
        imem[0] = enc_i(6'h08, 0, 1, 16'd7);
        imem[1] = enc_i(6'h2B, 0, 1, 16'd4);
        init_dmem();
        saved = dmem[1];
        do_reset();
        wait_pulse("mr");
        repeat (4) @(negedge i_clk);
        chk("mr_we_in_mem", 32'(o_d_we), 32'd1);
        chk("mr_addr_in_mem", o_d_addr, 32'd4);
        chk("mr_data_in_mem", o_d_wdata, 32'd7);
        #1 i_rst = 1'b1;
        #1;
        chk("mr_we_async", 32'(o_d_we), 32'd0);
        chk("mr_pc_async", o_i_addr, 32'd0);
        @(posedge i_clk);
        #1;
        chk("mr_no_store", dmem[1], saved);
        imem[0] = enc_i(6'h2B, 0, 1, 16'd4);          // r1 must read 0 now
        imem[1] = enc_i(6'h2B, 0, 1, 16'd8);
        run_prog("mr_after");

        // randomized programs
        for (int p = 0; p < 8; p++) begin
            clear_imem();
            for (int i = 0; i < 20; i++) begin
                r = $urandom_range(0, 9);
                case (r)
                    0, 1: imem[i] = enc_i(6'h08, $urandom_range(0, 7), $urandom_range(1, 7),
                                          16'(int'($urandom_range(0, 200)) - 100));
                    2, 3, 4: imem[i] = enc_r($urandom_range(0, 7), $urandom_range(0, 7),
                                             $urandom_range(0, 7), $urandom_range(0, 31),
                                             fl[(i % 7 == 6) ? 12 : $urandom_range(0, 11)]);
                    5, 8: imem[i] = enc_i(6'h2B, 0, $urandom_range(0, 7), 16'($urandom_range(0, 1023) * 4));
                    6: imem[i] = enc_i(6'h23, 0, $urandom_range(1, 7), 16'($urandom_range(0, 1023) * 4));
                    7: imem[i] = enc_i(($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05,
                                       $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom_range(0, 2)));
                    default: imem[i] = enc_i(($urandom_range(0, 1) != 0) ? 6'h2B : 6'h23,
                                             $urandom_range(0, 7), $urandom_range(1, 7), 16'($urandom_range(0, 63)));
                endcase
            end
            run_prog($sformatf("rnd%0d", p));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
